uart_transmitter: RTL

Serial transmit stage directly downstream of the memory-mapped UART controller. It accepts one byte per DataInValid/DataInReady handshake and serializes it onto SOut as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit. The baud rate comes from a clock divider. DataInReady is the status bit the controller returns on reads of the transmitter-control address.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_transmitter.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

    // Clock cycles per serial symbol; truncating division, must come out >= 2.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Symbol timer: counts 0..SymbolEdgeTime-1 and flags the last cycle of each symbol.
// Held at zero while clear is high so a new symbol starts aligned to the caller.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
    localparam int unsigned CountWidth     = $clog2(SymbolEdgeTime);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(SymbolEdgeTime - 1);

    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;

    assign tick = (count_q == LastCount);

    // Next count: hold at zero on clear, wrap after the last cycle of a symbol.
    always_comb begin
        count_d = count_q + CountWidth'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter: one byte per DataInValid/DataInReady handshake,
// start bit, 8 data bits LSB first, stop bit. SOut comes straight from a flop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       sout_q, sout_d;
    logic       tick;
    logic       handshake;

    assign DataInReady = (state_q == IDLE);
    assign handshake   = DataInValid && DataInReady;
    assign SOut        = sout_q;

    // The counter sits at zero through IDLE, so START begins a fresh symbol.
    uart_baud_tick #(
        .ClockFreq (ClockFreq),
        .BaudRate  (BaudRate)
    ) u_baud_tick (
        .Clock (Clock),
        .Reset (Reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    // Next-state, shift register and line level. The line level is derived from the
    // next state so the registered SOut lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        sout_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = START;
                    shift_d = DataIn;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LastBit) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
        endcase

        unique case (state_d)
            START:   sout_d = 1'b0;
            DATA:    sout_d = shift_d[0];
            default: sout_d = 1'b1;
        endcase
    end

    // State, data and line registers; reset aborts any frame and idles the line.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            sout_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            sout_q    <= sout_d;
        end
    end

endmodule
